// File: rtl/net_inertial_delay_if.sv
// Driver/net signal bundle for net_inertial_delay; remaining is sized from the effective delay D.
// NET_INERTIAL_CANCEL_CNT_EN adds the 16-bit cancel_cnt signal to both modports.
interface net_inertial_delay_if #(
  parameter int W = 1,
  parameter int D = 2
);
  localparam int RW = (D < 1) ? 1 : $clog2(D + 1);

  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          pending;
  logic [W-1:0]  target;
  logic [RW-1:0] remaining;
  logic          cancel;

`ifdef NET_INERTIAL_CANCEL_CNT_EN
  logic [15:0]   cancel_cnt;

  modport master (output din, input dout, pending, target, remaining, cancel, cancel_cnt);
  modport slave  (input din, output dout, pending, target, remaining, cancel, cancel_cnt);
`else
  modport master (output din, input dout, pending, target, remaining, cancel);
  modport slave  (input din, output dout, pending, target, remaining, cancel);
`endif

endinterface

// File: rtl/net_inertial_delay.sv
// Cycle-based inertial-delay model of a delayed net (assignment delay + net delay).
// Optional feature: define NET_INERTIAL_CANCEL_CNT_EN for a saturating 16-bit cancel counter.
module net_inertial_delay #(
  parameter int             W          = 1,
  parameter int             ASSIGN_DLY = 1,
  parameter int             NET_DLY    = 1,
  parameter logic [W-1:0]   RESET_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  net_inertial_delay_if.slave bus
);

  localparam int D  = ASSIGN_DLY + NET_DLY;
  localparam int RW = (D < 1) ? 1 : $clog2(D + 1);
  localparam logic [RW-1:0] CNT_LOAD = RW'(D - 1);

  if (D < 1) begin : g_bad_delay
    $error("net_inertial_delay: ASSIGN_DLY + NET_DLY must be at least 1");
  end

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  target_q, target_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          cancel_q, cancel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dout_q   <= RESET_VAL;
      target_q <= RESET_VAL;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
    end
  end

  // Case equality keeps X/Z on din a distinct value in simulation.
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    cancel_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.din !== dout_q) begin
          target_d = bus.din;
          cnt_d    = CNT_LOAD;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (cnt_q == '0) begin
          // Commit edge: the matured value lands even if din moved this edge.
          dout_d = target_q;
          if (bus.din === target_q) begin
            state_d = IDLE;
          end else begin
            target_d = bus.din;
            cnt_d    = CNT_LOAD;
          end
        end else if (bus.din === target_q) begin
          cnt_d = cnt_q - RW'(1);
        end else if (bus.din === dout_q) begin
          state_d  = IDLE;
          target_d = dout_q;
          cnt_d    = '0;
          cancel_d = 1'b1;
        end else begin
          target_d = bus.din;
          cnt_d    = CNT_LOAD;
          cancel_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        target_d = dout_q;
        cnt_d    = '0;
      end
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.pending   = (state_q == PENDING);
  assign bus.target    = target_q;
  assign bus.remaining = (state_q == PENDING) ? (cnt_q + RW'(1)) : '0;
  assign bus.cancel    = cancel_q;

`ifdef NET_INERTIAL_CANCEL_CNT_EN
  logic [15:0] cancel_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cancel_cnt_q <= '0;
    end else if (cancel_d && (cancel_cnt_q != 16'hFFFF)) begin
      cancel_cnt_q <= cancel_cnt_q + 16'd1;
    end
  end

  assign bus.cancel_cnt = cancel_cnt_q;
`endif

endmodule

// File: tb/tb_net_inertial_delay.sv
// Self-checking bench for net_inertial_delay: two instances (D=2 and D=3) share one din stream,
// checked every cycle against a "last D samples agree" inertial model plus directed literals.
module tb_net_inertial_delay;

  localparam int W = 8;
  localparam int N = 2;
  localparam logic [W-1:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;

  always #5 clk = ~clk;

  net_inertial_delay_if #(.W(W), .D(2)) if_a ();
  net_inertial_delay_if #(.W(W), .D(3)) if_b ();

  assign if_a.din = din;
  assign if_b.din = din;

  net_inertial_delay #(.W(W), .ASSIGN_DLY(1), .NET_DLY(1), .RESET_VAL(RV)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  net_inertial_delay #(.W(W), .ASSIGN_DLY(2), .NET_DLY(1), .RESET_VAL(RV)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int edge_no = 0;

  logic [W-1:0] m_dout    [N];
  logic [W-1:0] m_target  [N];
  logic         m_pending [N];
  logic         m_cancel  [N];
  int           m_rem     [N];
  int           m_ccnt    [N];
  logic [W-1:0] hist [$];
  bit           model_valid = 1'b0;

  function automatic int dlyOf(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s @edge %0d: got %0h, expected %0h", name, edge_no, got, exp);
    end
  endtask

  // Model: dout takes v once the D samples before an edge all equal v; otherwise
  // the newest sample, if it differs from dout, is the scheduled target.
  always @(posedge clk) begin : compare
    logic         s_rst;
    logic [W-1:0] s_din, prev_din, v;
    logic [W-1:0] prev_dout [N];
    logic         prev_pend [N];
    bit           all_same;
    int           d, rl;
    s_rst = rst;
    s_din = din;
    edge_no++;
    #1;
    if (s_rst) begin
      model_valid = 1'b1;
      hist.delete();
      for (int i = 0; i < N; i++) begin
        m_dout[i]    = RV;
        m_target[i]  = RV;
        m_pending[i] = 1'b0;
        m_cancel[i]  = 1'b0;
        m_rem[i]     = 0;
        m_ccnt[i]    = 0;
      end
    end else if (model_valid) begin
      for (int i = 0; i < N; i++) begin
        d = dlyOf(i);
        prev_dout[i] = m_dout[i];
        prev_pend[i] = m_pending[i];
        if (hist.size() >= d) begin
          v = hist[hist.size() - 1];
          all_same = 1'b1;
          for (int j = 1; j <= d; j++)
            if (hist[hist.size() - j] != v) all_same = 1'b0;
          if (all_same) m_dout[i] = v;
        end
      end
      prev_din = (hist.size() > 0) ? hist[hist.size() - 1] : RV;
      hist.push_back(s_din);
      if (hist.size() > 8) void'(hist.pop_front());
      rl = 0;
      for (int j = hist.size() - 1; j >= 0; j--) begin
        if (hist[j] != s_din) break;
        rl++;
      end
      for (int i = 0; i < N; i++) begin
        d = dlyOf(i);
        if (s_din == m_dout[i]) begin
          m_pending[i] = 1'b0;
          m_target[i]  = m_dout[i];
          m_rem[i]     = 0;
        end else begin
          m_pending[i] = 1'b1;
          m_target[i]  = s_din;
          m_rem[i]     = d - rl + 1;
        end
        m_cancel[i] = prev_pend[i] && (s_din != prev_din) && (m_dout[i] == prev_dout[i]);
        if (m_cancel[i] && m_ccnt[i] < 16'hFFFF) m_ccnt[i]++;
      end
    end
    if (model_valid) begin
      checkOutput("dout[0]",      if_a.dout,      m_dout[0]);
      checkOutput("pending[0]",   if_a.pending,   m_pending[0]);
      checkOutput("target[0]",    if_a.target,    m_target[0]);
      checkOutput("remaining[0]", if_a.remaining, m_rem[0]);
      checkOutput("cancel[0]",    if_a.cancel,    m_cancel[0]);
      checkOutput("dout[1]",      if_b.dout,      m_dout[1]);
      checkOutput("pending[1]",   if_b.pending,   m_pending[1]);
      checkOutput("target[1]",    if_b.target,    m_target[1]);
      checkOutput("remaining[1]", if_b.remaining, m_rem[1]);
      checkOutput("cancel[1]",    if_b.cancel,    m_cancel[1]);
`ifdef NET_INERTIAL_CANCEL_CNT_EN
      checkOutput("cancel_cnt[0]", if_a.cancel_cnt, m_ccnt[0]);
      checkOutput("cancel_cnt[1]", if_b.cancel_cnt, m_ccnt[1]);
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic [W-1:0] d);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [W-1:0] val;
    int           hold;
    logic         rst_first;
  } vec_t;

  vec_t table_v [12] = '{
    '{8'h11, 3, 1'b0}, '{8'h22, 1, 1'b0}, '{8'h33, 2, 1'b0}, '{8'h44, 4, 1'b0},
    '{8'h55, 1, 1'b0}, '{8'h44, 1, 1'b0}, '{8'h66, 2, 1'b0}, '{8'h77, 3, 1'b0},
    '{8'h88, 5, 1'b1}, '{8'h99, 2, 1'b0}, '{8'h88, 1, 1'b0}, '{8'hAA, 3, 1'b0}
  };

  int cancels_a, cancels_b;

  initial begin : stimulus
    applyStimulus(1'b1, 8'h00);                 // edge 2: reset held for edges 1-2
    checkOutput("rst_dout_a",      if_a.dout, 0);
    checkOutput("rst_pending_a",   if_a.pending, 0);
    checkOutput("rst_remaining_a", if_a.remaining, 0);
    checkOutput("rst_cancel_a",    if_a.cancel, 0);
    checkOutput("rst_target_b",    if_b.target, 0);

    applyStimulus(1'b0, 8'h01);                 // edge 3
    checkOutput("e3_pending_a",    if_a.pending, 1);
    checkOutput("e3_remaining_a",  if_a.remaining, 2);
    checkOutput("e3_remaining_b",  if_b.remaining, 3);
    checkOutput("e3_model_rem_a",  m_rem[0], 2);
    applyStimulus(1'b0, 8'h01);                 // edge 4
    checkOutput("e4_dout_a",       if_a.dout, 0);
    checkOutput("e4_remaining_a",  if_a.remaining, 1);
    applyStimulus(1'b0, 8'h01);                 // edge 5
    checkOutput("e5_dout_a",       if_a.dout, 1);
    checkOutput("e5_pending_a",    if_a.pending, 0);
    checkOutput("e5_model_dout_a", m_dout[0], 1);
    checkOutput("e5_dout_b",       if_b.dout, 0);
    applyStimulus(1'b0, 8'h01);                 // edge 6
    checkOutput("e6_dout_b",       if_b.dout, 1);

    applyStimulus(1'b0, 8'h00);                 // edge 7: short pulse back to 0
    checkOutput("e7_pending_a",    if_a.pending, 1);
    applyStimulus(1'b0, 8'h01);                 // edge 8
    checkOutput("e8_cancel_a",     if_a.cancel, 1);
    checkOutput("e8_pending_a",    if_a.pending, 0);
    checkOutput("e8_dout_a",       if_a.dout, 1);
    checkOutput("e8_cancel_b",     if_b.cancel, 1);
    checkOutput("e8_model_cancel", m_cancel[0], 1);
    applyStimulus(1'b0, 8'h01);                 // edge 9
    checkOutput("e9_cancel_a",     if_a.cancel, 0);

    applyStimulus(1'b1, 8'h00);                 // edge 10
    applyStimulus(1'b0, 8'h11);                 // edge 11
    checkOutput("e11_target_b",    if_b.target, 8'h11);
    applyStimulus(1'b0, 8'h22);                 // edge 12: reschedule
    checkOutput("e12_cancel_b",    if_b.cancel, 1);
    checkOutput("e12_target_b",    if_b.target, 8'h22);
    checkOutput("e12_remaining_b", if_b.remaining, 3);
    applyStimulus(1'b0, 8'h22);                 // edge 13
    checkOutput("e13_dout_b",      if_b.dout, 8'h00);
    applyStimulus(1'b0, 8'h22);                 // edge 14
    checkOutput("e14_dout_b",      if_b.dout, 8'h00);
    checkOutput("e14_dout_a",      if_a.dout, 8'h22);
    applyStimulus(1'b0, 8'h22);                 // edge 15
    checkOutput("e15_dout_b",      if_b.dout, 8'h22);
    checkOutput("e15_pending_b",   if_b.pending, 0);

    applyStimulus(1'b0, 8'hA5);                 // edge 16
    applyStimulus(1'b0, 8'hA5);                 // edge 17
    applyStimulus(1'b0, 8'h5A);                 // edge 18: commit edge with a change
    checkOutput("e18_dout_a",      if_a.dout, 8'hA5);
    checkOutput("e18_cancel_a",    if_a.cancel, 0);
    checkOutput("e18_target_a",    if_a.target, 8'h5A);
    checkOutput("e18_remaining_a", if_a.remaining, 2);
    applyStimulus(1'b0, 8'h5A);                 // edge 19
    checkOutput("e19_dout_a",      if_a.dout, 8'hA5);
    applyStimulus(1'b0, 8'h5A);                 // edge 20
    checkOutput("e20_dout_a",      if_a.dout, 8'h5A);

    applyStimulus(1'b0, 8'h33);                 // edge 21
    checkOutput("e21_pending_a",   if_a.pending, 1);
    applyStimulus(1'b1, 8'h44);                 // edge 22: reset mid-pending
    checkOutput("e22_dout_a",      if_a.dout, 0);
    checkOutput("e22_pending_a",   if_a.pending, 0);
    checkOutput("e22_cancel_a",    if_a.cancel, 0);
    checkOutput("e22_target_a",    if_a.target, 0);
    checkOutput("e22_pending_b",   if_b.pending, 0);
`ifdef NET_INERTIAL_CANCEL_CNT_EN
    checkOutput("e22_cancel_cnt_a", if_a.cancel_cnt, 0);
`endif

    cancels_a = 0;
    cancels_b = 0;
    for (int k = 0; k < 20; k++) begin          // edges 23-42
      applyStimulus(1'b0, (k % 2 == 0) ? 8'h0F : 8'hF0);
      if (if_a.cancel) cancels_a++;
      if (if_b.cancel) cancels_b++;
    end
    checkOutput("alt_cancels_a",   cancels_a, 19);
    checkOutput("alt_cancels_b",   cancels_b, 19);
    checkOutput("alt_dout_a",      if_a.dout, 0);
    checkOutput("alt_dout_b",      if_b.dout, 0);
`ifdef NET_INERTIAL_CANCEL_CNT_EN
    checkOutput("alt_cancel_cnt_a", if_a.cancel_cnt, 19);
    checkOutput("alt_cancel_cnt_b", if_b.cancel_cnt, 19);
`endif

    foreach (table_v[t]) begin
      if (table_v[t].rst_first) applyStimulus(1'b1, table_v[t].val);
      for (int h = 0; h < table_v[t].hold; h++) applyStimulus(1'b0, table_v[t].val);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'hAA);
    checkOutput("end_dout_a",      if_a.dout, 8'hAA);
    checkOutput("end_dout_b",      if_b.dout, 8'hAA);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("[TB] FAIL watchdog: got timeout at edge %0d, expected end of stimulus", edge_no);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
